rsa_modexp_core: RTL and testbench

//  RSA encryption datapath driven by the RSA enable/IRQ controller: computes cipher = plain^e mod n.

---
 rtl/rsa_modexp_core_if.sv | 23 ++
 rtl/rsa_modexp_core.sv | 157 +++++++++++++++
 tb/tb_rsa_modexp_core.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_core_if.sv
// Operand / control / result bundle between the RSA enable controller,
// the SPI register bank and the modular-exponentiation core.
interface rsa_if #(
  parameter int WIDTH = 8
);
  logic             en_rsa;
  logic             clear_rsa;
  logic [WIDTH-1:0] plain_text;
  logic [WIDTH-1:0] exp_e;
  logic [WIDTH-1:0] mod_n;
  logic [WIDTH-1:0] cipher_text;
  logic             eoc_rsa;

  modport master (
    output en_rsa, clear_rsa, plain_text, exp_e, mod_n,
    input  cipher_text, eoc_rsa
  );

  modport slave (
    input  en_rsa, clear_rsa, plain_text, exp_e, mod_n,
    output cipher_text, eoc_rsa
  );
endinterface

// File: rtl/rsa_modexp_core.sv
// Constant-time RSA modular exponentiation: cipher = plain^e mod n.
// Left-to-right square-and-always-multiply; each modular product is formed
// bit-serially by interleaved shift/add/subtract, one multiplier bit per cycle.
module rsa_modexp_core #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  rsa_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m_r, m_nxt;
  logic [WIDTH-1:0] e_r, e_nxt;
  logic [WIDTH-1:0] n_r, n_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH+1:0] p_r, p_nxt;
  logic [IW-1:0]    i_r, i_nxt;
  logic [IW-1:0]    j_r, j_nxt;
  logic             bad_r, bad_nxt;
  logic [WIDTH-1:0] ct_r, ct_nxt;
  logic             eoc_r, eoc_nxt;
  logic [WIDTH+1:0] step_res;
  logic [WIDTH-1:0] mcand;

  // One interleaved modmul step: P = 2P + bit*b, then reduce below n.
  // With P < n and b < n the sum stays below 3n, so two subtracts suffice.
  function automatic logic [WIDTH+1:0] mod_step(
    input logic [WIDTH+1:0] p,
    input logic             mbit,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] n
  );
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] nx;
    nx = {2'b00, n};
    t  = {p[WIDTH:0], 1'b0} + (mbit ? {2'b00, b} : '0);
    if (t >= nx) t = t - nx;
    if (t >= nx) t = t - nx;
    return t;
  endfunction

  // Square uses acc as multiplicand; multiply uses the latched message.
  assign mcand    = (state == MUL) ? m_r : acc;
  assign step_res = mod_step(p_r, acc[j_r], mcand, n_r);

  assign bus.cipher_text = ct_r;
  assign bus.eoc_rsa     = eoc_r;

  // Next-state and datapath: clear beats abort, abort beats the FSM.
  always_comb begin
    state_nxt = state;
    m_nxt     = m_r;
    e_nxt     = e_r;
    n_nxt     = n_r;
    acc_nxt   = acc;
    p_nxt     = p_r;
    i_nxt     = i_r;
    j_nxt     = j_r;
    bad_nxt   = bad_r;
    ct_nxt    = ct_r;
    eoc_nxt   = eoc_r;
    if (!bus.clear_rsa) begin
      state_nxt = IDLE;
      ct_nxt    = '0;
      eoc_nxt   = 1'b0;
    end else if (!bus.en_rsa) begin
      state_nxt = IDLE;
      eoc_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m_nxt     = bus.plain_text;
          e_nxt     = bus.exp_e;
          n_nxt     = bus.mod_n;
          bad_nxt   = (bus.mod_n < WIDTH'(2)) || (bus.plain_text >= bus.mod_n);
          acc_nxt   = WIDTH'(1);
          p_nxt     = '0;
          i_nxt     = IDX_MAX;
          j_nxt     = IDX_MAX;
          eoc_nxt   = 1'b0;
          state_nxt = SQR;
        end
        SQR: begin
          if (j_r == '0) begin
            acc_nxt   = step_res[WIDTH-1:0];
            p_nxt     = '0;
            j_nxt     = IDX_MAX;
            state_nxt = MUL;
          end else begin
            p_nxt = step_res;
            j_nxt = j_r - IDX_ONE;
          end
        end
        MUL: begin
          if (j_r == '0) begin
            // Product is always computed; only committed when the exponent bit is set.
            if (e_r[i_r]) acc_nxt = step_res[WIDTH-1:0];
            p_nxt = '0;
            j_nxt = IDX_MAX;
            if (i_r == '0) begin
              state_nxt = DONE;
            end else begin
              i_nxt     = i_r - IDX_ONE;
              state_nxt = SQR;
            end
          end else begin
            p_nxt = step_res;
            j_nxt = j_r - IDX_ONE;
          end
        end
        DONE: begin
          ct_nxt  = bad_r ? '0 : acc;
          eoc_nxt = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and datapath registers; ena=0 freezes everything except reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
      m_r   <= '0;
      e_r   <= '0;
      n_r   <= '0;
      acc   <= '0;
      p_r   <= '0;
      i_r   <= '0;
      j_r   <= '0;
      bad_r <= 1'b0;
      ct_r  <= '0;
      eoc_r <= 1'b0;
    end else if (ena) begin
      state <= state_nxt;
      m_r   <= m_nxt;
      e_r   <= e_nxt;
      n_r   <= n_nxt;
      acc   <= acc_nxt;
      p_r   <= p_nxt;
      i_r   <= i_nxt;
      j_r   <= j_nxt;
      bad_r <= bad_nxt;
      ct_r  <= ct_nxt;
      eoc_r <= eoc_nxt;
    end
  end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed and randomised checks of rsa_modexp_core against hand values
// and a straightforward repeated-multiply pow-mod reference.
module tb_rsa_modexp_core;

  logic clk;
  logic rstb;
  logic ena;
  int   checks;
  int   errors;

  rsa_if #(.WIDTH(8)) bus ();

  rsa_modexp_core #(.WIDTH(8)) dut (
    .clk  (clk),
    .rstb (rstb),
    .ena  (ena),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int powmod(input int m, input int e, input int n);
    int r;
    if (n < 2 || m >= n) return 0;
    r = 1 % n;
    for (int k = 0; k < e; k++) r = (r * m) % n;
    return r;
  endfunction

  // Abort any prior run, start a new one, count edges until eoc rises.
  // Operands are scrambled right after the start edge. With pause_at>0,
  // ena is held low for 20 edges starting after edge pause_at.
  task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] e,
                        input logic [7:0] n, input int expv, input int pause_at);
    int cnt;
    bit done;
    @(negedge clk);
    bus.en_rsa = 1'b0;
    bus.clear_rsa = 1'b1;
    @(negedge clk);
    bus.plain_text = m;
    bus.exp_e = e;
    bus.mod_n = n;
    bus.en_rsa = 1'b1;
    cnt = 0;
    done = 1'b0;
    while (!done && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 1) begin
        bus.plain_text = 8'($urandom);
        bus.exp_e = 8'($urandom);
        bus.mod_n = 8'($urandom);
      end
      if (pause_at > 0 && cnt == pause_at) ena = 1'b0;
      if (pause_at > 0 && cnt == pause_at + 20) ena = 1'b1;
      if (bus.eoc_rsa) done = 1'b1;
    end
    check({tag, "_lat"}, cnt - 1, (pause_at > 0) ? 149 : 129);
    check({tag, "_ct"}, int'(bus.cipher_text), expv);
  endtask

  initial begin
    int m, e, n;
    checks = 0;
    errors = 0;
    rstb = 1'b0;
    ena = 1'b1;
    bus.en_rsa = 1'b0;
    bus.clear_rsa = 1'b1;
    bus.plain_text = '0;
    bus.exp_e = '0;
    bus.mod_n = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ct", int'(bus.cipher_text), 0);
    check("rst_eoc", int'(bus.eoc_rsa), 0);
    @(negedge clk);
    rstb = 1'b1;

    run_op("m4e13n253", 8'd4, 8'd13, 8'd253, 108, 0);
    run_op("m4e13n221", 8'd4, 8'd13, 8'd221, 4, 0);
    // eoc and result held while en_rsa stays high
    repeat (5) @(posedge clk);
    #1;
    check("hold_eoc", int'(bus.eoc_rsa), 1);
    check("hold_ct", int'(bus.cipher_text), 4);
    @(negedge clk);
    bus.en_rsa = 1'b0;
    @(posedge clk);
    #1;
    check("abort_eoc", int'(bus.eoc_rsa), 0);
    check("abort_ct", int'(bus.cipher_text), 4);

    run_op("m3e5n7", 8'd3, 8'd5, 8'd7, 5, 0);
    run_op("e0", 8'd5, 8'd0, 8'd7, 1, 0);
    run_op("m0", 8'd0, 8'd3, 8'd7, 0, 0);
    run_op("m_ge_n", 8'd9, 8'd3, 8'd7, 0, 0);
    run_op("n1", 8'd0, 8'd3, 8'd1, 0, 0);
    run_op("m200e255n251", 8'd200, 8'd255, 8'd251, powmod(200, 255, 251), 0);

    // clear mid-run: start, clear after 50 edges
    run_op("pre_clr", 8'd4, 8'd13, 8'd253, 108, 0);
    @(negedge clk);
    bus.en_rsa = 1'b0;
    @(negedge clk);
    bus.plain_text = 8'd2;
    bus.exp_e = 8'd7;
    bus.mod_n = 8'd11;
    bus.en_rsa = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    bus.clear_rsa = 1'b0;
    @(posedge clk);
    #1;
    check("clr_ct", int'(bus.cipher_text), 0);
    check("clr_eoc", int'(bus.eoc_rsa), 0);
    run_op("post_clr", 8'd2, 8'd7, 8'd11, 7, 0);

    // ena pause stretches latency 1:1
    run_op("ena_pause", 8'd7, 8'd11, 8'd187, powmod(7, 11, 187), 30);

    // reset mid-run
    @(negedge clk);
    bus.en_rsa = 1'b0;
    @(negedge clk);
    bus.en_rsa = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    rstb = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_ct", int'(bus.cipher_text), 0);
    check("rstmid_eoc", int'(bus.eoc_rsa), 0);
    @(negedge clk);
    rstb = 1'b1;
    run_op("post_rst", 8'd10, 8'd3, 8'd13, 12, 0);

    // random sweep
    for (int k = 0; k < 250; k++) begin
      n = $urandom_range(0, 255);
      if ((k % 8) == 0) m = $urandom_range(0, 255);
      else m = (n > 0) ? $urandom_range(0, n - 1) : 0;
      e = $urandom_range(0, 255);
      run_op("rnd", 8'(m), 8'(e), 8'(n), powmod(m, e, n), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
